digit_shift_receiver: RTL and testbench
=======================================

// Module: digit_shift_receiver
// PURPOSE
//   Serial-to-parallel receiver for the 7-segment digit link; the far end of the digit shifter.
//   The transmitter loads {dp,led[6:0]} on an en&&load cycle, then shifts LSB-first, one bit per
//   en cycle. This block rebuilds each 8-bit digit and assembles NUM_DIGITS digits into a display
//   image. It publishes the image atomically when the last digit completes.
// PARAMETERS
//   NUM_DIGITS  4  digits per display frame (>=1); digit index width DW = max(1,$clog2(NUM_DIGITS))
// PORTS
//   clk           in   1              system clock, all state on posedge
//   rst_n         in   1              asynchronous active-low reset
//   en            in   1              link bit-enable, same strobe that drives the transmitter
//   load          in   1              digit boundary: en&&load marks the transmitter load cycle
//   sync          in   1              frame boundary: next digit received is digit 0
//   serial_in     in   1              serial data, sampled on posedge when en&&!load
//   digit_valid   out  1              1-cycle pulse: a complete digit was captured
//   digit_idx     out  DW             index of the digit that digit_valid reports
//   led_out       out  7              segments of the last captured digit
//   dp_out        out  1              decimal point of the last captured digit
//   frame_valid   out  1              1-cycle pulse: display updated with a full frame
//   display       out  8*NUM_DIGITS   published image, digit k at [8k+7:8k] = {dp,led[6:0]}
//   frame_err     out  1              sticky: short digit (load before 8 bits), cleared by sync
//   overrun       out  1              sticky: >8 shift cycles without load, cleared by sync
// BEHAVIOUR
//   - Reset: state=IDLE, bit_cnt=0, didx=0, shift reg=0, staging=0. All outputs are 0.
//   - en low: all state holds, including the pulses, which are low. load and serial_in are ignored.
//   - sync acts independently of en. It sets didx=0, clears staging, frame_err and overrun.
//   - FSM states:
//     IDLE  : waits for en&&load, then goes to SHIFT with bit_cnt=0.
//     SHIFT : on en&&!load, sr <= {serial_in, sr[7:1]} and bit_cnt++.
//             When the 8th bit shifts in (bit_cnt==7), go to DONE.
//     DONE  : en&&!load sets overrun=1 and does not shift; the digit data is kept.
//             en&&load goes back to SHIFT, bit_cnt=0.
//   - en&&load in SHIFT with bit_cnt!=0: set frame_err=1, drop the partial digit, restart SHIFT.
//     didx does not advance. A load with bit_cnt==0 simply restarts SHIFT; it is not an error.
//   - Digit completion happens on the edge that takes the 8th bit:
//     * next cycle: digit_valid=1, digit_idx=didx, {dp_out,led_out}= the byte just assembled
//       (first bit received -> led_out[0], eighth bit -> dp_out)
//     * staging[didx] <= byte
//     * didx advances, wrapping from NUM_DIGITS-1 to 0
//     * latency: 1 cycle from the 8th sampling edge to digit_valid
//   - When the completed digit has didx==NUM_DIGITS-1, in the same cycle as digit_valid:
//     display <= staging with the final byte merged in, and frame_valid=1.
//     display only changes at this point; it never shows a partial frame.
//   - led_out, dp_out and digit_idx hold their values between pulses.
//   - sync on the same edge as a digit completion: the completion is reported, staged and
//     published first. sync then forces didx=0 and clears staging.
//   - sync together with en&&load: both take effect. The new digit is digit 0.
//   - rst_n low mid-digit or mid-frame: everything is cleared asynchronously.
//     The next data needs a load to be received.
// STRUCTURE
//   - Shared package digit_link_pkg:
//     DIGIT_BITS=8; SEG_BITS=7; typedef digit_t {dp,led[6:0]}; enum rx_state_t {IDLE,SHIFT,DONE}.
//     The same constants are used by the transmitter side.
//   - One sub-module, digit_deserializer: shift register, bit counter and FSM.
//     It outputs byte and byte_done, plus short/overrun strobes.
//   - The top level keeps the digit index, staging array, display publish and sticky flags.
// TESTING
//   1 Single digit, NUM_DIGITS=1: load, then shift bits 1,0,0,1,1,1,1,0
//     -> digit_valid one cycle after the 8th bit, led_out=7'h79, dp_out=0,
//        frame_valid=1, display=8'h79.
//   2 Four-digit frame 0x3F,0x06,0x5B,0xCF with en active every 3rd clock
//     -> 4 digit_valid pulses with idx 0..3, one frame_valid, display=32'hCF5B063F.
//     display is unchanged before the 4th digit completes.
//   3 Load after 5 bits -> frame_err=1, no digit_valid, didx unchanged.
//     A following full digit 0x06 is captured at that same index.
//   4 Full digit then 3 extra en cycles without load -> overrun=1, led_out unchanged.
//     sync clears overrun and frame_err.
//   5 rst_n pulsed low after 4 bits of digit 2 -> all outputs 0 immediately.
//     A new frame then starts from digit 0 after the next load.
//   6 sync on the 8th-bit edge of digit 1 -> digit_valid with idx 1. The next digit reports idx 0.

Source files
------------

// File: rtl/digit_link_pkg.sv
// Shared constants and types for the 7-segment digit link (transmitter and receiver sides).
package digit_link_pkg;

    localparam int unsigned DIGIT_BITS = 8;
    localparam int unsigned SEG_BITS   = 7;
    localparam int unsigned CNT_W      = 3;

    typedef struct packed {
        logic                dp;
        logic [SEG_BITS-1:0] led;
    } digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } rx_state_t;

    // Digit index width; a single-digit display still needs a one-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/digit_deserializer.sv
// Rebuilds one LSB-first digit byte per load; strobes the completing byte combinationally.
module digit_deserializer
    import digit_link_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_en,
    input  logic   i_load,
    input  logic   i_serial_in,
    output digit_t o_byte_c,
    output logic   o_byte_done_c,
    output logic   o_short_c,
    output logic   o_overrun_c
);

    rx_state_t               r_state;
    logic [CNT_W-1:0]        r_bit_cnt;
    logic [DIGIT_BITS-1:0]   r_sr;

    logic                    w_shift;
    logic                    w_last_bit;
    logic [DIGIT_BITS-1:0]   w_sr_next;

    assign w_shift    = i_en && !i_load;
    assign w_last_bit = (r_bit_cnt == CNT_W'(DIGIT_BITS - 1));
    assign w_sr_next  = {i_serial_in, r_sr[DIGIT_BITS-1:1]};

    // The byte is exposed on the edge that takes its 8th bit so the top can register it there.
    assign o_byte_c      = digit_t'(w_sr_next);
    assign o_byte_done_c = w_shift && (r_state == SHIFT) && w_last_bit;
    assign o_short_c     = i_en && i_load && (r_state == SHIFT) && (r_bit_cnt != '0);
    assign o_overrun_c   = w_shift && (r_state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_sr      <= '0;
        end else if (i_en) begin
            if (i_load) begin
                r_state   <= SHIFT;
                r_bit_cnt <= '0;
            end else begin
                case (r_state)
                    SHIFT: begin
                        r_sr      <= w_sr_next;
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        if (w_last_bit) begin
                            r_state <= DONE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/digit_shift_receiver.sv
// Receiver end of the digit link: collects digits into a staging image and publishes whole frames.
module digit_shift_receiver
    import digit_link_pkg::*;
#(
    parameter  int unsigned NUM_DIGITS = 4,
    localparam int unsigned DW         = idx_width(NUM_DIGITS),
    localparam int unsigned IMG_W      = DIGIT_BITS * NUM_DIGITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                load,
    input  logic                sync,
    input  logic                serial_in,
    output logic                digit_valid,
    output logic [DW-1:0]       digit_idx,
    output logic [SEG_BITS-1:0] led_out,
    output logic                dp_out,
    output logic                frame_valid,
    output logic [IMG_W-1:0]    display,
    output logic                frame_err,
    output logic                overrun
);

    localparam logic [DW-1:0] LAST_IDX = DW'(NUM_DIGITS - 1);

    digit_t             w_byte;
    logic               w_done;
    logic               w_short;
    logic               w_overrun;
    logic               w_last_digit;
    logic [IMG_W-1:0]   w_merged;

    logic [DW-1:0]      r_didx;
    logic [IMG_W-1:0]   r_staging;

    digit_deserializer u_deser (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_en          (en),
        .i_load        (load),
        .i_serial_in   (serial_in),
        .o_byte_c      (w_byte),
        .o_byte_done_c (w_done),
        .o_short_c     (w_short),
        .o_overrun_c   (w_overrun)
    );

    assign w_last_digit = (r_didx == LAST_IDX);

    // Staging image with the completing byte dropped into its slot.
    always_comb begin
        w_merged = r_staging;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (r_didx == DW'(k)) begin
                w_merged[k*DIGIT_BITS +: DIGIT_BITS] = w_byte;
            end
        end
    end

    // Per-digit report and frame publish; sync is applied after the completion it coincides with.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_valid <= 1'b0;
            frame_valid <= 1'b0;
            digit_idx   <= '0;
            led_out     <= '0;
            dp_out      <= 1'b0;
            display     <= '0;
            r_didx      <= '0;
            r_staging   <= '0;
        end else begin
            digit_valid <= w_done;
            frame_valid <= w_done && w_last_digit;
            if (w_done) begin
                digit_idx <= r_didx;
                led_out   <= w_byte.led;
                dp_out    <= w_byte.dp;
                r_staging <= w_merged;
                if (w_last_digit) begin
                    display <= w_merged;
                    r_didx  <= '0;
                end else begin
                    r_didx  <= r_didx + DW'(1);
                end
            end
            if (sync) begin
                r_didx    <= '0;
                r_staging <= '0;
            end
        end
    end

    // Sticky link errors, cleared only by a frame sync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (sync) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (w_short) begin
                frame_err <= 1'b1;
            end
            if (w_overrun) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_digit_shift_receiver.sv
// Bench for digit_shift_receiver: 4-digit and 1-digit instances on shared stimulus vs a bit-count model.
module tb_digit_shift_receiver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic load = 1'b0;
    logic sync = 1'b0;
    logic serial_in = 1'b0;

    always #5 clk = ~clk;

    logic        a_dv, a_dp, a_fv, a_ferr, a_ovr;
    logic [1:0]  a_idx;
    logic [6:0]  a_led;
    logic [31:0] a_disp;

    logic        b_dv, b_dp, b_fv, b_ferr, b_ovr;
    logic [0:0]  b_idx;
    logic [6:0]  b_led;
    logic [7:0]  b_disp;

    digit_shift_receiver #(.NUM_DIGITS(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .sync(sync), .serial_in(serial_in),
        .digit_valid(a_dv), .digit_idx(a_idx), .led_out(a_led), .dp_out(a_dp),
        .frame_valid(a_fv), .display(a_disp), .frame_err(a_ferr), .overrun(a_ovr)
    );

    digit_shift_receiver #(.NUM_DIGITS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .sync(sync), .serial_in(serial_in),
        .digit_valid(b_dv), .digit_idx(b_idx), .led_out(b_led), .dp_out(b_dp),
        .frame_valid(b_fv), .display(b_disp), .frame_err(b_ferr), .overrun(b_ovr)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts data bits since the last load; 8 completes a digit, more is overrun.
    bit          m_armed [2];
    int          m_cnt   [2];
    logic [7:0]  m_acc   [2];
    int          m_didx  [2];
    logic [7:0]  m_stage [2][4];
    logic [31:0] m_disp  [2];
    logic        m_dv [2], m_fv [2], m_ferr [2], m_ovr [2];
    int          m_idx   [2];
    logic [7:0]  m_last  [2];

    function automatic int ndig(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_armed[k] = 1'b0; m_cnt[k] = 0; m_acc[k] = '0; m_didx[k] = 0;
            m_disp[k] = '0; m_dv[k] = 1'b0; m_fv[k] = 1'b0; m_ferr[k] = 1'b0;
            m_ovr[k] = 1'b0; m_idx[k] = 0; m_last[k] = '0;
            for (int j = 0; j < 4; j++) m_stage[k][j] = '0;
        end
    endtask

    task automatic model_step(input int k);
        m_dv[k] = 1'b0;
        m_fv[k] = 1'b0;
        if (en) begin
            if (load) begin
                if (m_armed[k] && m_cnt[k] > 0 && m_cnt[k] < 8) m_ferr[k] = 1'b1;
                m_armed[k] = 1'b1;
                m_cnt[k] = 0;
            end else if (m_armed[k]) begin
                if (m_cnt[k] < 8) begin
                    m_acc[k][3'(m_cnt[k])] = serial_in;
                    m_cnt[k]++;
                    if (m_cnt[k] == 8) begin
                        m_dv[k] = 1'b1;
                        m_idx[k] = m_didx[k];
                        m_last[k] = m_acc[k];
                        m_stage[k][m_didx[k]] = m_acc[k];
                        if (m_didx[k] == ndig(k) - 1) begin
                            m_fv[k] = 1'b1;
                            m_disp[k] = '0;
                            for (int j = 0; j < ndig(k); j++) m_disp[k][j*8 +: 8] = m_stage[k][j];
                        end
                        m_didx[k] = (m_didx[k] + 1) % ndig(k);
                    end
                end else begin
                    m_ovr[k] = 1'b1;
                end
            end
        end
        if (sync) begin
            m_didx[k] = 0;
            for (int j = 0; j < 4; j++) m_stage[k][j] = '0;
            m_ferr[k] = 1'b0;
            m_ovr[k] = 1'b0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else begin
            model_step(0);
            model_step(1);
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("a_digit_valid", a_dv,   m_dv[0]);
        chk("a_digit_idx",   a_idx,  m_idx[0]);
        chk("a_led_out",     a_led,  m_last[0][6:0]);
        chk("a_dp_out",      a_dp,   m_last[0][7]);
        chk("a_frame_valid", a_fv,   m_fv[0]);
        chk("a_display",     a_disp, m_disp[0]);
        chk("a_frame_err",   a_ferr, m_ferr[0]);
        chk("a_overrun",     a_ovr,  m_ovr[0]);
        chk("b_digit_valid", b_dv,   m_dv[1]);
        chk("b_digit_idx",   b_idx,  m_idx[1]);
        chk("b_led_out",     b_led,  m_last[1][6:0]);
        chk("b_dp_out",      b_dp,   m_last[1][7]);
        chk("b_frame_valid", b_fv,   m_fv[1]);
        chk("b_display",     b_disp, m_disp[1][7:0]);
        chk("b_frame_err",   b_ferr, m_ferr[1]);
        chk("b_overrun",     b_ovr,  m_ovr[1]);
    end

    task automatic step(input logic e, input logic l, input logic s, input logic d);
        @(negedge clk);
        #1;
        en = e; load = l; sync = s; serial_in = d;
    endtask

    // Load, 8 LSB-first bits with gap idle cycles between enables; returns with the result visible.
    task automatic send_digit(input logic [7:0] b, input int gap, input bit sync_last);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (gap) step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, (sync_last && i == 7), b[i]);
            if (i != 7) repeat (gap) step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    logic [7:0] t1_bits;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset_digit_valid", a_dv, 32'd0);
        chk("reset_display", a_disp, 32'd0);
        chk("reset_led", a_led, 32'd0);
        rst_n = 1'b1;

        // Single digit on the 1-digit instance: bits 1,0,0,1,1,1,1,0
        t1_bits = 8'b0111_1001;
        send_digit(t1_bits, 0, 1'b0);
        chk("t1_digit_valid", b_dv, 32'd1);
        chk("t1_led_out", b_led, 32'h79);
        chk("t1_dp_out", b_dp, 32'd0);
        chk("t1_frame_valid", b_fv, 32'd1);
        chk("t1_display", b_disp, 32'h79);
        chk("t1_model_led", m_last[1][6:0], 32'h79);
        chk("t1_a_no_frame", a_fv, 32'd0);

        // Four-digit frame, en every 3rd clock
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send_digit(8'h3F, 2, 1'b0);
        chk("t2_idx0", a_idx, 32'd0);
        send_digit(8'h06, 2, 1'b0);
        chk("t2_idx1", a_idx, 32'd1);
        send_digit(8'h5B, 2, 1'b0);
        chk("t2_idx2", a_idx, 32'd2);
        chk("t2_display_held", a_disp, 32'd0);
        send_digit(8'hCF, 2, 1'b0);
        chk("t2_idx3", a_idx, 32'd3);
        chk("t2_frame_valid", a_fv, 32'd1);
        chk("t2_display", a_disp, 32'hCF5B063F);
        chk("t2_model_display", m_disp[0], 32'hCF5B063F);
        chk("t2_dp_out", a_dp, 32'd1);
        chk("t2_led_out", a_led, 32'h4F);

        // Short digit, then a full digit at the same index
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send_digit(8'h11, 0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b1);
        send_digit(8'h06, 0, 1'b0);
        chk("t3_frame_err", a_ferr, 32'd1);
        chk("t3_idx", a_idx, 32'd1);
        chk("t3_led", a_led, 32'h06);

        // Overrun after a complete digit, then sync clears both flags
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_overrun", a_ovr, 32'd1);
        chk("t4_led_held", a_led, 32'h06);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_overrun_clr", a_ovr, 32'd0);
        chk("t4_ferr_clr", a_ferr, 32'd0);

        // Reset in the middle of digit 2
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send_digit(8'h5B, 0, 1'b0);
        send_digit(8'h3F, 0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_display", a_disp, 32'd0);
        chk("t5_led", a_led, 32'd0);
        chk("t5_idx", a_idx, 32'd0);
        chk("t5_b_display", b_disp, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_no_digit", a_dv, 32'd0);
        send_digit(8'h06, 0, 1'b0);
        chk("t5_new_idx", a_idx, 32'd0);
        chk("t5_new_led", a_led, 32'h06);

        // Sync on the 8th-bit edge of digit 1
        step(1'b0, 1'b0, 1'b1, 1'b0);
        send_digit(8'h11, 0, 1'b0);
        send_digit(8'h22, 0, 1'b1);
        chk("t6_idx1", a_idx, 32'd1);
        chk("t6_dv", a_dv, 32'd1);
        send_digit(8'h33, 0, 1'b0);
        chk("t6_idx0", a_idx, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(499) == 0) pulse_reset();
            step(($urandom_range(2) != 0), ($urandom_range(9) == 0),
                 ($urandom_range(63) == 0), 1'($urandom_range(1)));
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
